// File: rtl/csr_defines_pkg.sv
// csr_defines: CSR address map, write masks, CSR op codes and TCFG layout
package csr_defines;
  localparam logic [7:0] EXE_CSRRD_OP   = 8'h60;
  localparam logic [7:0] EXE_CSRWR_OP   = 8'h61;
  localparam logic [7:0] EXE_CSRXCHG_OP = 8'h62;
  localparam logic [13:0] CSR_CRMD   = 14'h0;
  localparam logic [13:0] CSR_PRMD   = 14'h1;
  localparam logic [13:0] CSR_EUEN   = 14'h2;
  localparam logic [13:0] CSR_ECFG   = 14'h4;
  localparam logic [13:0] CSR_ESTAT  = 14'h5;
  localparam logic [13:0] CSR_ERA    = 14'h6;
  localparam logic [13:0] CSR_BADV   = 14'h7;
  localparam logic [13:0] CSR_EENTRY = 14'hC;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_SAVE1  = 14'h31;
  localparam logic [13:0] CSR_SAVE2  = 14'h32;
  localparam logic [13:0] CSR_SAVE3  = 14'h33;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;
  localparam logic [31:0] CRMD_RESET = 32'h8;
  typedef struct packed {
    logic [29:0] init_val;
    logic        periodic;
    logic        en;
  } csr_tcfg_t;
  function automatic logic [31:0] csr_wmask(input logic [13:0] a);
    case (a)
      CSR_CRMD:   return 32'h1FF;
      CSR_PRMD:   return 32'h7;
      CSR_EUEN:   return 32'h1;
      CSR_ECFG:   return 32'h1BFF;
      CSR_ESTAT:  return 32'h3;
      CSR_EENTRY: return 32'hFFFF_FFC0;
      CSR_TICLR:  return 32'h1;
      CSR_ERA, CSR_BADV, CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3, CSR_TID, CSR_TCFG:
        return 32'hFFFF_FFFF;
      default:    return 32'h0;
    endcase
  endfunction
endpackage

// File: rtl/csr_exec_unit_timer.sv
// csr_timer: TVAL countdown with periodic reload and TCFG-write load; pulses ti_set on 1->0
module csr_timer
  import csr_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tcfg,
  input  logic        tcfg_we,
  input  logic [29:0] tcfg_init,
  output logic [31:0] tval,
  output logic        ti_set
);
  csr_tcfg_t cfg;
  assign cfg = tcfg;
  assign ti_set = ~tcfg_we & cfg.en & (tval == 32'd1);
  always_ff @(posedge clk) begin
    if (rst) tval <= '0;
    else if (tcfg_we) tval <= {tcfg_init, 2'b00};
    else if (cfg.en) tval <= (tval != '0) ? tval - 32'd1 : cfg.periodic ? {cfg.init_val, 2'b00} : '0;
  end
endmodule

// File: rtl/csr_exec_unit.sv
// csr_exec_unit: executes CSRRD/CSRWR/CSRXCHG on the CSR file, returns old value one cycle later
module csr_exec_unit
  import csr_defines::*;
#(
  parameter int          DATA_WIDTH    = 32,
  parameter int          ALU_OP_WIDTH  = 8,
  parameter int          CSR_NUM_WIDTH = 14,
  parameter logic [31:0] TID_RESET     = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [ALU_OP_WIDTH-1:0]  aluop_i,
  input  logic [CSR_NUM_WIDTH-1:0] csr_num_i,
  input  logic [DATA_WIDTH-1:0]    rd_data_i,
  input  logic [DATA_WIDTH-1:0]    rj_data_i,
  input  logic [4:0]               rd_addr_i,
  output logic                     valid_o,
  output logic                     wb_en_o,
  output logic [4:0]               wb_addr_o,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  output logic                     timer_int_o
);
  logic [31:0] crmd, prmd, euen, ecfg, estat, era, badv, eentry, tid, tcfg, tval;
  logic [31:0] save0, save1, save2, save3;
  logic [31:0] old, merged, wmask, stored;
  logic fire, is_rd, is_wr, is_xchg, we, ti_set;
  assign fire    = valid_i & ~stall_i & ~flush_i;
  assign is_rd   = aluop_i == EXE_CSRRD_OP;
  assign is_wr   = aluop_i == EXE_CSRWR_OP;
  assign is_xchg = aluop_i == EXE_CSRXCHG_OP;
  assign we      = fire & (is_wr | is_xchg);
  assign wmask   = csr_wmask(csr_num_i);
  assign merged  = is_xchg ? (rd_data_i & rj_data_i) | (old & ~rj_data_i) : rd_data_i;
  assign stored  = (merged & wmask) | (old & ~wmask);
  assign timer_int_o = estat[11];
  always_comb begin
    old = '0;
    case (csr_num_i)
      CSR_CRMD:   old = crmd;
      CSR_PRMD:   old = prmd;
      CSR_EUEN:   old = euen;
      CSR_ECFG:   old = ecfg;
      CSR_ESTAT:  old = estat;
      CSR_ERA:    old = era;
      CSR_BADV:   old = badv;
      CSR_EENTRY: old = eentry;
      CSR_SAVE0:  old = save0;
      CSR_SAVE1:  old = save1;
      CSR_SAVE2:  old = save2;
      CSR_SAVE3:  old = save3;
      CSR_TID:    old = tid;
      CSR_TCFG:   old = tcfg;
      CSR_TVAL:   old = tval;
      default:    old = '0;
    endcase
  end
  csr_timer u_timer (
    .clk(clk), .rst(rst), .tcfg(tcfg), .tcfg_we(we & (csr_num_i == CSR_TCFG)),
    .tcfg_init(stored[31:2]), .tval(tval), .ti_set(ti_set)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      crmd <= CRMD_RESET;
      {prmd, euen, ecfg, estat, era, badv, eentry, tcfg} <= '0;
      {save0, save1, save2, save3} <= '0;
      tid <= TID_RESET;
    end else begin
      if (we) begin
        case (csr_num_i)
          CSR_CRMD:   crmd <= stored;
          CSR_PRMD:   prmd <= stored;
          CSR_EUEN:   euen <= stored;
          CSR_ECFG:   ecfg <= stored;
          CSR_ESTAT:  estat <= stored;
          CSR_ERA:    era <= stored;
          CSR_BADV:   badv <= stored;
          CSR_EENTRY: eentry <= stored;
          CSR_SAVE0:  save0 <= stored;
          CSR_SAVE1:  save1 <= stored;
          CSR_SAVE2:  save2 <= stored;
          CSR_SAVE3:  save3 <= stored;
          CSR_TID:    tid <= stored;
          CSR_TCFG:   tcfg <= stored;
          default: ;
        endcase
      end
      // a timer expiry on the same edge as a TICLR write must not be lost
      if (ti_set) estat[11] <= 1'b1;
      else if (we && csr_num_i == CSR_TICLR && stored[0]) estat[11] <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o   <= 1'b0;
      wb_en_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
    end else if (fire) begin
      valid_o   <= 1'b1;
      wb_en_o   <= is_rd | is_wr | is_xchg;
      wb_addr_o <= rd_addr_i;
      wb_data_o <= old;
    end else if (flush_i | ~stall_i) begin
      valid_o <= 1'b0;
      wb_en_o <= 1'b0;
    end
  end
endmodule
